bram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32-bit block RAM between the instruction-fetch port (I) and the load/store port (D) of the processor. It selects one request per cycle and drives the RAM address, write data and write enable. It returns the RAM's one-cycle-late read data to the winning port with a registered response strobe. Misaligned and out-of-range accesses are rejected with an error response and never reach the RAM.

---
 rtl/bram_arb_pkg.sv | 28 ++
 rtl/bram_arb_addr_chk.sv | 13 +
 rtl/bram_arbiter.sv | 123 ++++++++++++
 tb/tb_bram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the I/D block-RAM arbiter: port ids, response record
// and the address legality check used by both ports.
package bram_arb_pkg;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned ADDR_BITS   = 16;
  localparam int unsigned DATA_BITS   = 32;
  localparam int unsigned CONSEC_BITS = 4;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } resp_t;

  localparam resp_t RESP_IDLE = '{valid: 1'b0, port: PORT_I, err: 1'b0};

  // Misaligned word access or any address bit above the implemented RAM range.
  function automatic logic addr_err(input logic [ADDR_BITS-1:0] a,
                                    input int unsigned adr_width);
    logic [ADDR_BITS-1:0] hi_mask;
    hi_mask = {ADDR_BITS{1'b1}} << adr_width;
    return (a[1:0] != 2'b00) || ((a & hi_mask) != '0);
  endfunction

endpackage

// File: rtl/bram_arb_addr_chk.sv
// Per-port address check: flags accesses that must not reach the RAM.
module bram_arb_addr_chk
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 11
) (
  input  logic [15:0] a,
  output logic        err
);

  assign err = addr_err(a, ADR_WIDTH);

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM between the I-fetch and load/store ports:
// D-priority arbitration with bounded I starvation, RAM mux, registered response.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH  = 11,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,

  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_a,
  input  logic [31:0] i_wdata,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_rerr,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_a,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_rerr,
  output logic [31:0] d_rdata,

  output logic [15:0] mem_a,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [CONSEC_BITS-1:0] MAX_C = CONSEC_BITS'(MAX_CONSEC);

  logic [1:0][15:0]            port_a;
  logic [1:0]                  port_err;
  logic [CONSEC_BITS-1:0]      consec_reg;
  logic [CONSEC_BITS-1:0]      consec_next;
  resp_t                       resp_reg;
  resp_t                       resp_next;
  logic                        i_win;
  logic                        d_win;
  logic                        i_starved;

  assign port_a = {d_a, i_a};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chk
      bram_arb_addr_chk #(
        .ADR_WIDTH(ADR_WIDTH)
      ) u_chk (
        .a   (port_a[gi]),
        .err (port_err[gi])
      );
    end
  endgenerate

  // I only overrides D once D has won MAX_CONSEC times in a row against it.
  assign i_starved = i_req && (consec_reg == MAX_C);

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (sys_rst_n) begin
      if (d_req && !i_starved) begin
        d_win = 1'b1;
      end else if (i_req) begin
        i_win = 1'b1;
      end
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  always_comb begin
    consec_next = '0;
    if (i_req && d_win) begin
      consec_next = consec_reg + CONSEC_BITS'(1);
    end
  end

  always_comb begin
    mem_a     = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    resp_next = RESP_IDLE;
    if (d_win) begin
      mem_a     = d_a;
      mem_wdata = d_wdata;
      mem_we    = d_we && !port_err[PORT_D];
      resp_next = '{valid: 1'b1, port: PORT_D, err: port_err[PORT_D]};
    end else if (i_win) begin
      mem_a     = i_a;
      mem_wdata = i_wdata;
      mem_we    = i_we && !port_err[PORT_I];
      resp_next = '{valid: 1'b1, port: PORT_I, err: port_err[PORT_I]};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      consec_reg <= '0;
      resp_reg   <= RESP_IDLE;
    end else begin
      consec_reg <= consec_next;
      resp_reg   <= resp_next;
    end
  end

  // The RAM's registered read data lines up with the response register.
  assign i_rvalid = resp_reg.valid && (resp_reg.port == PORT_I);
  assign i_rerr   = i_rvalid && resp_reg.err;
  assign i_rdata  = (i_rvalid && !resp_reg.err) ? mem_rdata : '0;

  assign d_rvalid = resp_reg.valid && (resp_reg.port == PORT_D);
  assign d_rerr   = d_rvalid && resp_reg.err;
  assign d_rdata  = (d_rvalid && !resp_reg.err) ? mem_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_bram_arbiter;

  localparam int ADR_WIDTH  = 11;
  localparam int MAX_CONSEC = 4;
  localparam int WORDS      = 512;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [15:0] i_a = '0;
  logic [31:0] i_wdata = '0;
  logic        i_gnt, i_rvalid, i_rerr;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_a = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_rerr;
  logic [31:0] d_rdata;
  logic [15:0] mem_a;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  bram_arbiter #(
    .ADR_WIDTH (ADR_WIDTH),
    .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_a      (i_a),
    .i_wdata  (i_wdata),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rerr   (i_rerr),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_a      (d_a),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rerr   (d_rerr),
    .d_rdata  (d_rdata),
    .mem_a    (mem_a),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 0) return 32'h0BAD0000;
    if (k == 3) return 32'hDEADBEEF;
    if (k == 4) return 32'hA5A50004;
    return 32'(k) * 32'h9E3779B1;
  endfunction

  // Read-before-write RAM; contents reload while reset is held.
  logic [31:0] ram [WORDS];
  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < WORDS; k++) ram[k] <= init_word(k);
      mem_rdata <= '0;
    end else begin
      mem_rdata <= ram[mem_a[10:2]];
      if (mem_we) ram[mem_a[10:2]] <= mem_wdata;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [15:0] a);
    return ((int'(a) % 4) != 0) || (int'(a) >= (1 << ADR_WIDTH));
  endfunction

  // Behavioural model state
  logic [31:0] model_mem [WORDS];
  int          consec_m;
  bit          exp_valid, exp_port, exp_err;
  logic [31:0] exp_data;
  bit          last_i_gnt, last_d_gnt;

  initial begin : cmp
    bit          wi, wdn, sel_we, e;
    logic [15:0] sel_a;
    logic [31:0] sel_wdata;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk16("rst_mem_a", mem_a, 16'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk1("rst_i_rerr", i_rerr, 1'b0);
        chk1("rst_d_rerr", d_rerr, 1'b0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        for (int k = 0; k < WORDS; k++) model_mem[k] = init_word(k);
        consec_m = 0;
        exp_valid = 0; exp_port = 0; exp_err = 0; exp_data = '0;
        last_i_gnt = 0; last_d_gnt = 0;
      end else begin
        chk1("i_rvalid", i_rvalid, exp_valid && !exp_port);
        chk1("d_rvalid", d_rvalid, exp_valid && exp_port);
        chk1("i_rerr", i_rerr, exp_valid && !exp_port && exp_err);
        chk1("d_rerr", d_rerr, exp_valid && exp_port && exp_err);
        chk32("i_rdata", i_rdata, (exp_valid && !exp_port) ? exp_data : 32'h0);
        chk32("d_rdata", d_rdata, (exp_valid && exp_port) ? exp_data : 32'h0);

        if (i_req && d_req) begin
          wi  = (consec_m == MAX_CONSEC);
          wdn = !wi;
        end else begin
          wi  = i_req;
          wdn = d_req;
        end
        chk1("i_gnt", i_gnt, wi);
        chk1("d_gnt", d_gnt, wdn);

        sel_a = wdn ? d_a : (wi ? i_a : 16'h0);
        sel_wdata = wdn ? d_wdata : (wi ? i_wdata : 32'h0);
        sel_we = wdn ? d_we : (wi ? i_we : 1'b0);
        e = (wi || wdn) && bad_addr(sel_a);
        chk16("mem_a", mem_a, sel_a);
        chk32("mem_wdata", mem_wdata, sel_wdata);
        chk1("mem_we", mem_we, sel_we && !e);

        exp_valid = wi || wdn;
        exp_port  = wdn;
        exp_err   = e;
        exp_data  = (exp_valid && !e) ? model_mem[sel_a[10:2]] : 32'h0;
        if (exp_valid && sel_we && !e) model_mem[sel_a[10:2]] = sel_wdata;
        consec_m  = (wdn && i_req) ? consec_m + 1 : 0;
        last_i_gnt = wi;
        last_d_gnt = wdn;
      end
    end
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rand_req(output logic req, output logic we, output logic [15:0] a,
                          output logic [31:0] wdata, input int we_pct);
    int r;
    req = ($urandom_range(0, 99) < 70);
    we  = ($urandom_range(0, 99) < we_pct);
    r   = $urandom_range(0, 9);
    if (r == 0)      a = 16'($urandom_range(0, 2047) & 32'h7FC) | 16'($urandom_range(1, 3));
    else if (r == 1) a = 16'h0800 | 16'($urandom_range(0, 16383) << 2);
    else             a = 16'($urandom_range(0, 63) << 2);
    wdata = $urandom;
  endtask

  logic [9:0] gseq;
  logic [4:0] gseq5;

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Single D read of word 3
    next_cycle();
    d_req = 1; d_we = 0; d_a = 16'h000C;
    @(negedge sys_clk);
    chk1("t1_d_gnt", d_gnt, 1'b1);
    chk16("t1_mem_a", mem_a, 16'h000C);
    next_cycle();
    d_req = 0;
    @(negedge sys_clk);
    chk1("t1_d_rvalid", d_rvalid, 1'b1);
    chk32("t1_d_rdata", d_rdata, 32'hDEADBEEF);
    chk1("t1_i_rvalid", i_rvalid, 1'b0);

    // Sustained contention
    next_cycle();
    i_req = 1; i_we = 0; i_a = 16'h0100;
    d_req = 1; d_we = 0; d_a = 16'h0104;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      gseq[k] = d_gnt;
      next_cycle();
    end
    chk16("contention_seq", 16'(gseq), 16'(10'b0111101111));
    i_req = 0; d_req = 0;

    // Write then read of word 4
    next_cycle();
    d_req = 1; d_we = 1; d_a = 16'h0010; d_wdata = 32'h12345678;
    @(negedge sys_clk);
    chk1("wr_d_gnt", d_gnt, 1'b1);
    chk1("wr_mem_we", mem_we, 1'b1);
    next_cycle();
    d_we = 0;
    @(negedge sys_clk);
    chk32("wr_old_word", d_rdata, 32'hA5A50004);
    next_cycle();
    d_req = 0;
    @(negedge sys_clk);
    chk32("rd_new_word", d_rdata, 32'h12345678);

    // Misaligned I read
    next_cycle();
    i_req = 1; i_a = 16'h0002;
    @(negedge sys_clk);
    chk1("err_i_gnt", i_gnt, 1'b1);
    chk1("err_i_mem_we", mem_we, 1'b0);
    next_cycle();
    i_req = 0;
    @(negedge sys_clk);
    chk1("err_i_rvalid", i_rvalid, 1'b1);
    chk1("err_i_rerr", i_rerr, 1'b1);
    chk32("err_i_rdata", i_rdata, 32'h0);

    // Out-of-range D write
    next_cycle();
    d_req = 1; d_we = 1; d_a = 16'h0800; d_wdata = 32'hFFFFFFFF;
    @(negedge sys_clk);
    chk1("err_d_gnt", d_gnt, 1'b1);
    chk1("err_d_mem_we", mem_we, 1'b0);
    next_cycle();
    d_req = 0; d_we = 0;
    @(negedge sys_clk);
    chk1("err_d_rerr", d_rerr, 1'b1);
    chk32("err_ram_word0", ram[0], 32'h0BAD0000);

    // Reset in the cycle after a D grant
    next_cycle();
    i_req = 1; i_a = 16'h0020; d_req = 1; d_a = 16'h0024;
    next_cycle();
    next_cycle();
    sys_rst_n = 0;
    @(negedge sys_clk);
    chk1("mid_rst_d_rvalid", d_rvalid, 1'b0);
    chk1("mid_rst_d_gnt", d_gnt, 1'b0);
    chk1("mid_rst_i_gnt", i_gnt, 1'b0);
    next_cycle();
    sys_rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      if (k == 0) chk1("post_rst_d_rvalid", d_rvalid, 1'b0);
      gseq5[k] = d_gnt;
      next_cycle();
    end
    chk16("post_rst_seq", 16'(gseq5), 16'(5'b01111));
    i_req = 0; d_req = 0;

    // Idle
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk1("idle_mem_we", mem_we, 1'b0);
      chk16("idle_mem_a", mem_a, 16'h0);
      chk1("idle_i_rvalid", i_rvalid, 1'b0);
      chk1("idle_d_rvalid", d_rvalid, 1'b0);
      next_cycle();
    end

    // Randomized traffic; requests held until granted
    for (int c = 0; c < 4000; c++) begin
      sys_rst_n = ($urandom_range(0, 299) != 0);
      if (!i_req || last_i_gnt) rand_req(i_req, i_we, i_a, i_wdata, 10);
      if (!d_req || last_d_gnt) rand_req(d_req, d_we, d_a, d_wdata, 40);
      next_cycle();
    end
    sys_rst_n = 1;
    i_req = 0; d_req = 0;
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
